// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: scoreboard of in-flight destinations (EX, MEM, WB),
// per-operand forwarding selects, load-use stall, branch flush and saturating event counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned NSTAGES  = 3,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned SEL_W    = $clog2(NSTAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   input  logic              ex_branch_taken,
   output logic              stall,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic [SEL_W-1:0]  fwd_sel_a,
   output logic [SEL_W-1:0]  fwd_sel_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              is_load;
   } sb_entry_t;

   sb_entry_t        sb_q [NSTAGES];
   sb_entry_t        sb_d [NSTAGES];
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             found_a, found_b;
   logic             lu_a, lu_b;
   logic [SEL_W-1:0] sel_a, sel_b;
   logic             stall_raw;

   // Ascending scan with a found flag: the lowest position (youngest producer) wins.
   always_comb begin
      found_a = 1'b0;
      found_b = 1'b0;
      lu_a    = 1'b0;
      lu_b    = 1'b0;
      sel_a   = '0;
      sel_b   = '0;
      for (int unsigned p = 0; p < NSTAGES; p++) begin
         if (sb_q[p].valid && sb_q[p].we && (sb_q[p].rd != '0)) begin
            if (!found_a && id_valid && id_rs1_used && (sb_q[p].rd == id_rs1)) begin
               found_a = 1'b1;
               sel_a   = SEL_W'(p + 1);
               lu_a    = sb_q[p].is_load && (p < LOAD_LAT);
            end
            if (!found_b && id_valid && id_rs2_used && (sb_q[p].rd == id_rs2)) begin
               found_b = 1'b1;
               sel_b   = SEL_W'(p + 1);
               lu_b    = sb_q[p].is_load && (p < LOAD_LAT);
            end
         end
      end
      stall_raw   = lu_a | lu_b;
      stall       = stall_raw & ~ex_branch_taken;
      flush_if_id = ex_branch_taken;
      flush_id_ex = ex_branch_taken;
      fwd_sel_a   = stall_raw ? '0 : sel_a;
      fwd_sel_b   = stall_raw ? '0 : sel_b;
   end

   always_comb begin
      for (int unsigned p = 1; p < NSTAGES; p++) begin
         sb_d[p] = sb_q[p-1];
      end
      if (stall || ex_branch_taken) begin
         sb_d[0] = '0;
      end else begin
         sb_d[0] = {id_valid, id_rd, id_rd_we, id_is_load};
      end
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ex_branch_taken && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned p = 0; p < NSTAGES; p++) begin
            sb_q[p] <= '0;
         end
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         for (int unsigned p = 0; p < NSTAGES; p++) begin
            sb_q[p] <= sb_d[p];
         end
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, saturation sequences,
// then random stimulus against a queue-based reference model of the pipeline history.
module tb_pipeline_hazard_ctrl;

   localparam int NST  = 3;
   localparam int LLAT = 1;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
   logic       ex_branch_taken;
   logic       stall, flush_if_id, flush_id_ex;
   logic [1:0] fwd_sel_a, fwd_sel_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
      .ex_branch_taken(ex_branch_taken),
      .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Reference model: history of what entered EX, index 0 = youngest.
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       we;
      bit       ld;
   } ent_t;

   ent_t hist[$];
   int   m_sc = 0;
   int   m_fc = 0;

   function automatic int youngest(input bit used, input bit [4:0] addr);
      if (!(used && id_valid) || addr == 0) return -1;
      for (int p = 0; p < hist.size(); p++)
         if (hist[p].v && hist[p].we && hist[p].rd == addr) return p;
      return -1;
   endfunction

   task automatic model_eval(output bit st, output bit fl, output int sa, output int sb);
      int  ia, ib;
      bit  raw;
      ia  = youngest(id_rs1_used, id_rs1);
      ib  = youngest(id_rs2_used, id_rs2);
      raw = (ia >= 0 && hist[ia].ld && ia < LLAT) || (ib >= 0 && hist[ib].ld && ib < LLAT);
      sa  = raw ? 0 : ia + 1;
      sb  = raw ? 0 : ib + 1;
      st  = raw && !ex_branch_taken;
      fl  = ex_branch_taken;
   endtask

   task automatic model_step();
      bit   st, fl;
      int   sa, sb;
      ent_t e;
      if (!rst) begin
         hist.delete();
         for (int i = 0; i < NST; i++) hist.push_back('{0, 0, 0, 0});
         m_sc = 0;
         m_fc = 0;
      end else begin
         model_eval(st, fl, sa, sb);
         e = '{0, 0, 0, 0};
         if (!(st || fl)) e = '{id_valid, id_rd, id_rd_we, id_is_load};
         hist.push_front(e);
         void'(hist.pop_back());
         if (st && m_sc < CMAX) m_sc++;
         if (fl && m_fc < CMAX) m_fc++;
      end
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit v, input bit [4:0] a, input bit ua,
                        input bit [4:0] b, input bit ub, input bit [4:0] d,
                        input bit w, input bit l, input bit br);
      rst = r; id_valid = v; id_rs1 = a; id_rs1_used = ua; id_rs2 = b; id_rs2_used = ub;
      id_rd = d; id_rd_we = w; id_is_load = l; ex_branch_taken = br;
   endtask

   task automatic end_cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   typedef struct packed {
      bit r, v; bit [4:0] a; bit ua; bit [4:0] b; bit ub; bit [4:0] d; bit w, l, br;
      bit chk, st, fl; bit [1:0] sa, sb; bit [3:0] sc, fc;
   } vec_t;

   function automatic vec_t mk(bit r, bit v, bit [4:0] a, bit ua, bit [4:0] b, bit ub,
                               bit [4:0] d, bit w, bit l, bit br, bit chk, bit st, bit fl,
                               bit [1:0] sa, bit [1:0] sb, bit [3:0] sc, bit [3:0] fc);
      return {r, v, a, ua, b, ub, d, w, l, br, chk, st, fl, sa, sb, sc, fc};
   endfunction

   vec_t tbl[$];

   initial begin
      bit st, fl;
      int sa, sb;
      vec_t t;

      //            r v rs1 u rs2 u rd we ld br chk st fl sa sb sc fc
      tbl.push_back(mk(0,1, 5,1, 5,1, 5,1,0,0, 0, 0,0,0,0,0,0)); // reset, dependence present
      tbl.push_back(mk(0,1, 5,1, 5,1, 5,1,0,0, 0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,1, 1,1, 0,0, 5,1,0,0, 1, 0,0,0,0,0,0)); // addi x5
      tbl.push_back(mk(1,1, 5,1, 5,1, 6,1,0,0, 1, 0,0,1,1,0,0)); // add x6,x5,x5
      tbl.push_back(mk(1,1, 5,1, 0,0, 0,0,0,0, 1, 0,0,2,0,0,0));
      tbl.push_back(mk(1,1, 5,1, 0,0, 0,0,0,0, 1, 0,0,3,0,0,0));
      tbl.push_back(mk(1,1, 5,1, 0,0, 0,0,0,0, 1, 0,0,0,0,0,0)); // x5 retired
      tbl.push_back(mk(1,1, 2,1, 0,0, 7,1,1,0, 1, 0,0,0,0,0,0)); // ld x7
      tbl.push_back(mk(1,1, 7,1, 1,1, 8,1,0,0, 1, 1,0,0,0,0,0)); // add x8,x7,x1 stalls
      tbl.push_back(mk(1,1, 7,1, 1,1, 8,1,0,0, 1, 0,0,2,0,1,0)); // retry forwards from MEM
      tbl.push_back(mk(1,1, 0,0, 0,0, 5,1,0,0, 1, 0,0,0,0,1,0)); // addi x5
      tbl.push_back(mk(1,1, 0,0, 0,0, 0,1,0,0, 1, 0,0,0,0,1,0)); // writes x0
      tbl.push_back(mk(1,1, 0,1, 5,0, 0,0,0,0, 1, 0,0,0,0,1,0)); // rs1=x0, rs2 unused
      tbl.push_back(mk(1,1, 0,0, 5,1, 0,0,0,0, 1, 0,0,0,3,1,0)); // rs2 used now
      tbl.push_back(mk(1,1, 0,0, 0,0, 7,1,1,0, 1, 0,0,0,0,1,0)); // ld x7
      tbl.push_back(mk(1,1, 7,1, 0,0, 9,1,0,1, 1, 0,1,0,0,1,0)); // dependent + branch
      tbl.push_back(mk(1,1, 9,1, 7,1, 0,0,0,0, 1, 0,0,0,2,1,1)); // squashed x9 not seen
      tbl.push_back(mk(1,1, 0,0, 0,0, 9,1,0,0, 1, 0,0,0,0,1,1)); // x9 producer
      tbl.push_back(mk(1,1, 0,0, 0,0, 9,1,0,0, 1, 0,0,0,0,1,1)); // x9 producer again
      tbl.push_back(mk(1,1, 9,1, 9,1, 0,0,0,0, 1, 0,0,1,1,1,1)); // youngest wins
      tbl.push_back(mk(1,1, 0,0, 0,0, 9,1,1,0, 1, 0,0,0,0,1,1)); // ld x9 over alu x9
      tbl.push_back(mk(1,1, 9,1, 0,0, 0,0,0,0, 1, 1,0,0,0,1,1)); // youngest is load
      tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 1, 0,0,0,0,2,1));

      for (int i = 0; i < NST; i++) hist.push_back('{0, 0, 0, 0});
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         t = tbl[i];
         drive(t.r, t.v, t.a, t.ua, t.b, t.ub, t.d, t.w, t.l, t.br);
         @(negedge clk);
         if (t.chk) begin
            cmp($sformatf("tbl%0d.stall", i), int'(stall), int'(t.st));
            cmp($sformatf("tbl%0d.flush_if_id", i), int'(flush_if_id), int'(t.fl));
            cmp($sformatf("tbl%0d.flush_id_ex", i), int'(flush_id_ex), int'(t.fl));
            cmp($sformatf("tbl%0d.fwd_sel_a", i), int'(fwd_sel_a), int'(t.sa));
            cmp($sformatf("tbl%0d.fwd_sel_b", i), int'(fwd_sel_b), int'(t.sb));
            cmp($sformatf("tbl%0d.stall_cnt", i), int'(stall_cnt), int'(t.sc));
            cmp($sformatf("tbl%0d.flush_cnt", i), int'(flush_cnt), int'(t.fc));
         end
         end_cycle();
      end

      // Saturation: 20 load-use stalls, then 20 taken branches.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end_cycle();
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 0, 0, 0, 7, 1, 1, 0);
         end_cycle();
         drive(1, 1, 7, 1, 0, 0, 8, 1, 0, 0);
         @(negedge clk);
         cmp($sformatf("sat%0d.stall", i), int'(stall), 1);
         end_cycle();
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmp("sat.stall_cnt", int'(stall_cnt), 15);
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
         @(negedge clk);
         cmp($sformatf("satb%0d.flush", i), int'(flush_if_id), 1);
         end_cycle();
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cmp("sat.flush_cnt", int'(flush_cnt), 15);
      cmp("sat.stall_cnt_hold", int'(stall_cnt), 15);
      end_cycle();

      // Random phase against the model.
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end_cycle();
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(63) != 0), ($urandom_range(9) != 0),
               5'($urandom_range(3)), ($urandom_range(3) != 0),
               5'($urandom_range(3)), ($urandom_range(3) != 0),
               5'($urandom_range(3)), ($urandom_range(9) < 7),
               ($urandom_range(9) < 3), ($urandom_range(7) == 0));
         @(negedge clk);
         model_eval(st, fl, sa, sb);
         cmp("rnd.stall", int'(stall), int'(st));
         cmp("rnd.flush_if_id", int'(flush_if_id), int'(fl));
         cmp("rnd.flush_id_ex", int'(flush_id_ex), int'(fl));
         cmp("rnd.fwd_sel_a", int'(fwd_sel_a), sa);
         cmp("rnd.fwd_sel_b", int'(fwd_sel_b), sb);
         cmp("rnd.stall_cnt", int'(stall_cnt), m_sc);
         cmp("rnd.flush_cnt", int'(flush_cnt), m_fc);
         end_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
